// File: rtl/mux_rr_pipe_if.sv
// Handshake bundle for mux_rr_pipe: NCH valid/ready input channels, arbitration controls,
// and one registered valid/ready output.
interface mux_rr_pipe_if #(
    parameter int unsigned nbits = 7,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*nbits-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic                 force_en;
    logic [SELW-1:0]      force_sel;
    logic [nbits-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, mode, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_rr_pipe.sv
// N-channel valid/ready mux with fixed-priority or round-robin arbitration, an optional forced
// channel, and a single registered output stage that refills in the cycle it drains.
module mux_rr_pipe #(
    parameter int unsigned nbits = 7,
    parameter int unsigned NCH   = 4
) (
    input logic          clk,
    input logic          rst,
    mux_rr_pipe_if.slave bus
);
    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [nbits-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   grant;
    logic [NCH-1:0]   ready;
    logic [2*NCH-1:0] elig_dbl;
    logic [2*NCH-1:0] oh_dbl;
    logic [NCH-1:0]   elig_rot;
    logic [NCH-1:0]   oh_rot;
    logic [SELW-1:0]  base;
    logic [SELW-1:0]  gidx;
    logic [nbits-1:0] gdata;
    logic             load;
    logic             xfer;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            elig[i] = bus.in_valid[i] & (~bus.force_en | (int'(bus.force_sel) == i));
        end
    end

    // Rotate so the scan starts at base, pick the lowest set bit, then rotate back.
    always_comb begin
        base     = bus.mode ? rr_ptr_q : '0;
        elig_dbl = {elig, elig} >> base;
        elig_rot = elig_dbl[NCH-1:0];
        oh_rot   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                oh_rot    = '0;
                oh_rot[i] = 1'b1;
            end
        end
        oh_dbl = {{NCH{1'b0}}, oh_rot} << base;
        grant  = oh_dbl[NCH-1:0] | oh_dbl[2*NCH-1:NCH];
    end

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gidx  = SELW'(i);
                gdata = bus.in_data[i*nbits +: nbits];
            end
        end
    end

    always_comb begin
        load  = ~out_valid_q | bus.out_ready;
        ready = {NCH{load & ~rst}} & grant;
        xfer  = |ready;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = gdata;
            out_sel_d   = gidx;
            out_valid_d = 1'b1;
            rr_ptr_d    = (int'(gidx) == NCH - 1) ? '0 : gidx + SELW'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed self-checking bench for mux_rr_pipe: a 4-channel instance for the main scenarios and
// a 5-channel instance so an out-of-range force_sel is representable.
module tb_mux_rr_pipe;
    localparam int unsigned NBITS = 7;
    localparam int unsigned NCH   = 4;
    localparam int unsigned NCH5  = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mux_rr_pipe_if #(.nbits(NBITS), .NCH(NCH))  bus ();
    mux_rr_pipe_if #(.nbits(NBITS), .NCH(NCH5)) bus5 ();

    mux_rr_pipe #(.nbits(NBITS), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux_rr_pipe #(.nbits(NBITS), .NCH(NCH5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [NBITS-1:0] v);
        bus.in_data[ch*NBITS +: NBITS] = v;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_data    = '0;
        bus.in_valid   = '0;
        bus.mode       = 1'b0;
        bus.force_en   = 1'b0;
        bus.force_sel  = '0;
        bus.out_ready  = 1'b1;
        bus5.in_data   = '0;
        bus5.in_valid  = '0;
        bus5.mode      = 1'b0;
        bus5.force_en  = 1'b0;
        bus5.force_sel = '0;
        bus5.out_ready = 1'b1;

        #2;
        check_eq("rst_in_ready", bus.in_ready, 4'b0000);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_data", bus.out_data, 7'h00);
        check_eq("rst_out_sel", bus.out_sel, 2'd0);
        check_eq("rst_rr_ptr", dut.rr_ptr_q, 2'd0);
        #10 rst = 1'b0;
        tick;

        // Fixed priority: channel 1 beats channel 3 every cycle.
        for (int i = 0; i < 4; i++) set_data(i, NBITS'(10 + i));
        bus.in_valid = 4'b1010;
        #1;
        check_eq("fp_in_ready0", bus.in_ready, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            tick;
            check_eq("fp_out_valid", bus.out_valid, 1'b1);
            check_eq("fp_out_sel", bus.out_sel, 2'd1);
            check_eq("fp_out_data", bus.out_data, 7'd11);
            check_eq("fp_in_ready", bus.in_ready, 4'b0010);
        end
        check_eq("fp_rr_ptr", dut.rr_ptr_q, 2'd2);

        // A channel-3 transfer wraps the pointer to 0.
        bus.in_valid = 4'b1000;
        tick;
        check_eq("ch3_out_sel", bus.out_sel, 2'd3);
        check_eq("ch3_out_data", bus.out_data, 7'd13);
        check_eq("ch3_rr_ptr", dut.rr_ptr_q, 2'd0);

        // Round-robin over all four channels.
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick;
            check_eq("rr_out_data", bus.out_data, 32'(10 + (k % 4)));
            check_eq("rr_out_sel", bus.out_sel, 32'(k % 4));
            check_eq("rr_out_valid", bus.out_valid, 1'b1);
        end
        check_eq("rr_ptr_after", dut.rr_ptr_q, 2'd2);

        // Backpressure holds 7'h2A for five cycles.
        set_data(2, 7'h2A);
        tick;
        check_eq("bp_first", bus.out_data, 7'h2A);
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_in_ready", bus.in_ready, 4'b0000);
            check_eq("bp_out_valid", bus.out_valid, 1'b1);
            check_eq("bp_out_data", bus.out_data, 7'h2A);
            check_eq("bp_out_sel", bus.out_sel, 2'd2);
            check_eq("bp_rr_ptr", dut.rr_ptr_q, 2'd3);
            tick;
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", bus.in_ready, 4'b1000);
        tick;
        check_eq("bp_next_data", bus.out_data, 7'd13);
        check_eq("bp_next_sel", bus.out_sel, 2'd3);
        check_eq("bp_next_ptr", dut.rr_ptr_q, 2'd0);

        // Force channel 2 with every channel valid.
        bus.force_en  = 1'b1;
        bus.force_sel = 2'd2;
        #1;
        check_eq("force_in_ready0", bus.in_ready, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            tick;
            check_eq("force_out_sel", bus.out_sel, 2'd2);
            check_eq("force_out_data", bus.out_data, 7'h2A);
            check_eq("force_in_ready", bus.in_ready, 4'b0100);
        end
        check_eq("force_rr_ptr", dut.rr_ptr_q, 2'd3);

        // Pointer at 3, only channel 0 valid: scan wraps to 0.
        bus.force_en = 1'b0;
        bus.in_valid = 4'b0001;
        #1;
        check_eq("wrap_in_ready", bus.in_ready, 4'b0001);
        tick;
        check_eq("wrap_out_sel", bus.out_sel, 2'd0);
        check_eq("wrap_out_data", bus.out_data, 7'd10);
        check_eq("wrap_rr_ptr", dut.rr_ptr_q, 2'd1);

        bus.in_valid = 4'b0000;
        tick;
        check_eq("idle_out_valid", bus.out_valid, 1'b0);
        check_eq("idle_out_data", bus.out_data, 7'd10);

        // Out-of-range force on the 5-channel instance.
        for (int i = 0; i < 5; i++) bus5.in_data[i*NBITS +: NBITS] = NBITS'(20 + i);
        bus5.in_valid = 5'b11111;
        tick;
        check_eq("n5_out_valid", bus5.out_valid, 1'b1);
        check_eq("n5_out_sel", bus5.out_sel, 3'd0);
        check_eq("n5_out_data", bus5.out_data, 7'd20);
        bus5.force_en  = 1'b1;
        bus5.force_sel = 3'd4;
        #1;
        check_eq("n5_force4_ready", bus5.in_ready, 5'b10000);
        bus5.force_sel = 3'd5;
        #1;
        check_eq("n5_force5_ready", bus5.in_ready, 5'b00000);
        tick;
        check_eq("n5_drain_valid", bus5.out_valid, 1'b0);
        tick;
        check_eq("n5_idle_valid", bus5.out_valid, 1'b0);
        check_eq("n5_idle_data", bus5.out_data, 7'd20);

        // Asynchronous reset while a word is held under backpressure.
        bus.mode     = 1'b0;
        set_data(1, 7'h55);
        bus.in_valid = 4'b0010;
        tick;
        check_eq("pre_rst_data", bus.out_data, 7'h55);
        check_eq("pre_rst_sel", bus.out_sel, 2'd1);
        check_eq("pre_rst_valid", bus.out_valid, 1'b1);
        check_eq("pre_rst_ptr", dut.rr_ptr_q, 2'd2);
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", bus.out_valid, 1'b0);
        check_eq("arst_out_data", bus.out_data, 7'h00);
        check_eq("arst_out_sel", bus.out_sel, 2'd0);
        check_eq("arst_rr_ptr", dut.rr_ptr_q, 2'd0);
        check_eq("arst_in_ready", bus.in_ready, 4'b0000);
        #5;
        rst = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
